sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 87 ++++++++
 tb/tb_sum_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums NUM_SAMPLES unsigned 5-bit beats, presents the total for one valid/ready handshake.
// Result valid one cycle after the final beat; the total holds in HOLD until out_ready, and beats stall while not in ACCUM.
`timescale 1ns/1ps
module sum_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int SUM_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       in_result,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [4:0] LAST_CNT = 5'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W:0]   sum_ext;

  // One extra bit captures the carry that flags overflow.
  assign sum_ext = {1'b0, acc_q} + {{(SUM_W - 4){1'b0}}, in_result};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_ext[SUM_W-1:0];
          cnt_d = cnt_q + 5'd1;
          if (sum_ext[SUM_W]) ovf_d = 1'b1;
          if (cnt_q == LAST_CNT) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: three configurations share one stimulus bus; each section resets all and checks one instance.
`timescale 1ns/1ps
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] in_result;
  logic       in_valid;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_overflow, a_busy;
  logic [8:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_overflow, b_busy;
  logic [4:0] b_out_sum;
  logic       c_in_ready, c_out_valid, c_overflow, c_busy;
  logic [8:0] c_out_sum;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_accumulator u_def (
    .clk(clk), .rst(rst), .start(start), .in_result(in_result), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_sum(a_out_sum), .out_valid(a_out_valid),
    .out_ready(out_ready), .overflow(a_overflow), .busy(a_busy)
  );

  sum_accumulator #(.NUM_SAMPLES(2), .SUM_W(5)) u_w5 (
    .clk(clk), .rst(rst), .start(start), .in_result(in_result), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_sum(b_out_sum), .out_valid(b_out_valid),
    .out_ready(out_ready), .overflow(b_overflow), .busy(b_busy)
  );

  sum_accumulator #(.NUM_SAMPLES(1), .SUM_W(9)) u_n1 (
    .clk(clk), .rst(rst), .start(start), .in_result(in_result), .in_valid(in_valid),
    .in_ready(c_in_ready), .out_sum(c_out_sum), .out_valid(c_out_valid),
    .out_ready(out_ready), .overflow(c_overflow), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [4:0] v);
    in_valid  = 1'b1;
    in_result = v;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_result = '0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  a_in_ready,  0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy",      a_busy,      0);
    chk("rst_out_sum",   a_out_sum,   0);
    chk("rst_overflow",  a_overflow,  0);
    rst = 1'b0;
    step();
    chk("idle_no_start_busy", a_busy, 0);

    // Default frame: 4 x 30 with in_valid held and out_ready high.
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("t1_in_ready", a_in_ready, 1);
      beat(5'd30);
    end
    chk("t1_in_ready_off", a_in_ready,  0);
    chk("t1_out_valid",    a_out_valid, 1);
    chk("t1_out_sum",      a_out_sum,   120);
    chk("t1_overflow",     a_overflow,  0);
    step();
    chk("t1_idle_valid", a_out_valid, 0);
    chk("t1_idle_busy",  a_busy,      0);
    chk("t1_idle_sum",   a_out_sum,   120);

    // Gaps and backpressure: 5,0,17,3 with idle cycles, consumer stalls 3 cycles.
    reset_all();
    out_ready = 1'b0;
    pulse_start();
    beat(5'd5);
    step();
    chk("t2_gap_sum", a_out_sum, 5);
    beat(5'd0);
    step();
    step();
    chk("t2_gap_ready", a_in_ready, 1);
    beat(5'd17);
    step();
    chk("t2_gap_sum2", a_out_sum, 22);
    beat(5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", a_out_valid, 1);
      chk("t2_hold_sum",   a_out_sum,   25);
      step();
    end
    chk("t2_hold_valid_last", a_out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("t2_released", a_out_valid, 0);

    // start pulses during ACCUM, HOLD and the handshake cycle are ignored.
    out_ready = 1'b0;
    pulse_start();
    start = 1'b1;
    beat(5'd2);
    beat(5'd2);
    beat(5'd2);
    beat(5'd2);
    chk("t5_hold_valid", a_out_valid, 1);
    chk("t5_hold_sum",   a_out_sum,   8);
    step();
    chk("t5_hold_stays", a_out_valid, 1);
    out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t5_idle_busy", a_busy,    0);
    chk("t5_idle_sum",  a_out_sum, 8);
    step();
    chk("t5_still_idle", a_busy, 0);

    // Asynchronous reset mid-frame, then a clean frame of 1,1,1,1.
    out_ready = 1'b1;
    pulse_start();
    beat(5'd7);
    beat(5'd9);
    chk("t4_mid_sum", a_out_sum, 16);
    in_valid = 1'b1; in_result = 5'd4;
    #2 rst = 1'b1;
    #1;
    chk("t4_arst_in_ready",  a_in_ready,  0);
    chk("t4_arst_busy",      a_busy,      0);
    chk("t4_arst_sum",       a_out_sum,   0);
    chk("t4_arst_valid",     a_out_valid, 0);
    chk("t4_arst_overflow",  a_overflow,  0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("t4_no_resume", a_busy, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) beat(5'd1);
    chk("t4_valid", a_out_valid, 1);
    chk("t4_sum",   a_out_sum,   4);

    // SUM_W=5, NUM_SAMPLES=2: wrap with sticky overflow, then cleared on next start.
    reset_all();
    out_ready = 1'b1;
    pulse_start();
    beat(5'd20);
    beat(5'd20);
    chk("t3_valid",    b_out_valid, 1);
    chk("t3_in_ready", b_in_ready,  0);
    chk("t3_sum",      b_out_sum,   8);
    chk("t3_overflow", b_overflow,  1);
    step();
    chk("t3_idle_ovf", b_overflow, 1);
    pulse_start();
    chk("t3_ovf_clear", b_overflow, 0);
    chk("t3_sum_clear", b_out_sum,  0);
    beat(5'd1);
    beat(5'd1);
    chk("t3_sum2",  b_out_sum,  2);
    chk("t3_ovf2",  b_overflow, 0);
    step();
    pulse_start();
    beat(5'd31);
    beat(5'd31);
    chk("t3_sum31", b_out_sum,  30);
    chk("t3_ovf31", b_overflow, 1);

    // NUM_SAMPLES=1: a single beat completes the frame.
    reset_all();
    out_ready = 1'b0;
    pulse_start();
    chk("t6_in_ready", c_in_ready, 1);
    beat(5'd13);
    chk("t6_valid",    c_out_valid, 1);
    chk("t6_in_ready_off", c_in_ready, 0);
    chk("t6_sum",      c_out_sum,   13);
    out_ready = 1'b1;
    step();
    pulse_start();
    beat(5'd31);
    chk("t6_sum31", c_out_sum,  31);
    chk("t6_ovf31", c_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
